// File: rtl/cpu_stage_controller_pkg.sv
// Shared definitions for the multi-cycle CPU stage controller.
// Holds the stage vector width, the one-hot bit index of each stage, the
// controller state encoding and the default retired-counter width, so the
// datapath, the debug port and the controller agree on a single layout.
package cpu_stage_controller_pkg;

  localparam int STAGE_COUNT_C  = 6;
  localparam int RETIRE_WIDTH_C = 16;

  // Bit positions inside the one-hot stage vector
  localparam int STAGE_IF  = 0;
  localparam int STAGE_ID  = 1;
  localparam int STAGE_OF  = 2;
  localparam int STAGE_EX  = 3;
  localparam int STAGE_MEM = 4;
  localparam int STAGE_WB  = 5;

  typedef enum logic [2:0] {
    ST_IF     = 3'd0,
    ST_ID     = 3'd1,
    ST_OF     = 3'd2,
    ST_EX     = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALTED = 3'd6
  } state_e;

  // One-hot stage vector for a state; HALTED has no active stage.
  function automatic logic [STAGE_COUNT_C-1:0] stage_onehot(input state_e s);
    logic [STAGE_COUNT_C-1:0] v;
    v = '0;
    case (s)
      ST_IF:   v[STAGE_IF]  = 1'b1;
      ST_ID:   v[STAGE_ID]  = 1'b1;
      ST_OF:   v[STAGE_OF]  = 1'b1;
      ST_EX:   v[STAGE_EX]  = 1'b1;
      ST_MEM:  v[STAGE_MEM] = 1'b1;
      ST_WB:   v[STAGE_WB]  = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cpu_stage_controller_retire_counter.sv
// Wrapping enable counter for retired instructions.
// Ports: clk, rst_n (async active-low), en (count this cycle),
//        count (current value, wraps modulo 2^WIDTH).
module cpu_stage_controller_retire_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en) count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/cpu_stage_controller.sv
// Multi-cycle CPU stage sequencer: walks one instruction at a time through
// IF, ID, OF, EX, MEM, WB, with second-word fetch, memory wait states,
// branch PC load and a terminal HALTED state.
// Ports:
//   clk, reset (async active-low)
//   stage         one-hot current stage (registered), zero when halted
//   fetch_req / fetch_ready   instruction memory handshake (IF)
//   instr_words, need_mem     decoder hints
//   mem_req / mem_ready       data memory handshake (MEM)
//   branch_taken, halt        WB-time control
//   pc_inc, pc_load, retire   one-cycle pulses (registered)
//   word_idx                  second instruction word in flight
//   retired_count, halted     status
// STAGE_COUNT must stay 6; the stage layout is fixed by the package.
module cpu_stage_controller
  import cpu_stage_controller_pkg::*;
#(
  parameter int STAGE_COUNT  = STAGE_COUNT_C,
  parameter int RETIRE_WIDTH = RETIRE_WIDTH_C
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic [STAGE_COUNT-1:0]  stage,
  output logic                    fetch_req,
  input  logic                    fetch_ready,
  input  logic                    instr_words,
  input  logic                    need_mem,
  output logic                    mem_req,
  input  logic                    mem_ready,
  input  logic                    branch_taken,
  input  logic                    halt,
  output logic                    pc_inc,
  output logic                    pc_load,
  output logic                    word_idx,
  output logic                    retire,
  output logic [RETIRE_WIDTH-1:0] retired_count,
  output logic                    halted
);

  state_e                 state_q, state_d;
  logic [STAGE_COUNT-1:0] stage_q, stage_d;
  logic word_idx_q, word_idx_d;
  logic pc_inc_q,   pc_inc_d;
  logic pc_load_q,  pc_load_d;
  logic retire_q,   retire_d;
  logic halted_q,   halted_d;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IF;
    else        state_q <= state_d;
  end

  // Next-state logic; ready inputs only matter in their owning stage
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IF:     if (fetch_ready) state_d = ST_ID;
      ST_ID:     state_d = (instr_words && !word_idx_q) ? ST_IF : ST_OF;
      ST_OF:     state_d = ST_EX;
      ST_EX:     state_d = ST_MEM;
      ST_MEM:    if (!need_mem || mem_ready) state_d = ST_WB;
      ST_WB:     state_d = halt ? ST_HALTED : ST_IF;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IF;
    endcase
  end

  // Output logic. Stage and pulses are computed for the next cycle and
  // registered, so they line up with state_q one cycle later. Retire and
  // pc_load are consequences of the WB just completed, so they still pulse
  // once in the first HALTED cycle when that WB carried halt.
  always_comb begin
    stage_d    = STAGE_COUNT'(stage_onehot(state_d));
    word_idx_d = word_idx_q;
    if (state_q == ST_ID && instr_words && !word_idx_q) word_idx_d = 1'b1;
    if (state_q == ST_WB)                               word_idx_d = 1'b0;
    pc_inc_d   = (state_q == ST_IF) && fetch_ready;
    pc_load_d  = (state_q == ST_WB) && branch_taken;
    retire_d   = (state_q == ST_WB);
    halted_d   = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_q    <= STAGE_COUNT'(stage_onehot(ST_IF));
      word_idx_q <= 1'b0;
      pc_inc_q   <= 1'b0;
      pc_load_q  <= 1'b0;
      retire_q   <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      stage_q    <= stage_d;
      word_idx_q <= word_idx_d;
      pc_inc_q   <= pc_inc_d;
      pc_load_q  <= pc_load_d;
      retire_q   <= retire_d;
      halted_q   <= halted_d;
    end
  end

  // Requests are combinational from state so reset drops them immediately
  assign fetch_req = (state_q == ST_IF);
  assign mem_req   = (state_q == ST_MEM) && need_mem;

  assign stage    = stage_q;
  assign word_idx = word_idx_q;
  assign pc_inc   = pc_inc_q;
  assign pc_load  = pc_load_q;
  assign retire   = retire_q;
  assign halted   = halted_q;

  cpu_stage_controller_retire_counter #(
    .WIDTH (RETIRE_WIDTH)
  ) u_retire_counter (
    .clk   (clk),
    .rst_n (reset),
    .en    (retire_d),
    .count (retired_count)
  );

endmodule

// File: tb/tb_cpu_stage_controller.sv
// Scoreboard bench for cpu_stage_controller. The stimulus process drives
// one cycle at a time and pushes the hand-derived expected outputs for that
// cycle; a negedge monitor pops and compares.
module tb_cpu_stage_controller;

  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    stage;
  logic          fetch_req, fetch_ready, instr_words, need_mem;
  logic          mem_req, mem_ready, branch_taken, halt;
  logic          pc_inc, pc_load, word_idx, retire, halted;
  logic [RW-1:0] retired_count;

  always #5 clk = ~clk;

  cpu_stage_controller #(.STAGE_COUNT(6), .RETIRE_WIDTH(RW)) dut (
    .clk(clk), .reset(reset), .stage(stage),
    .fetch_req(fetch_req), .fetch_ready(fetch_ready),
    .instr_words(instr_words), .need_mem(need_mem),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .halt(halt),
    .pc_inc(pc_inc), .pc_load(pc_load), .word_idx(word_idx),
    .retire(retire), .retired_count(retired_count), .halted(halted)
  );

  typedef struct {
    logic [5:0]    stage;
    logic          freq, mreq, pinc, pload, ret, widx, hlt;
    logic [RW-1:0] cnt;
  } snap_t;

  snap_t q[$];
  int    n_chk  = 0;
  int    n_fail = 0;

  logic [RW-1:0] exp_cnt;
  logic          pend_ret, pend_load, exp_halt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every cycle with a pending expectation is compared
  always @(negedge clk) begin
    snap_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("stage",         32'(stage),         32'(e.stage));
      chk("fetch_req",     32'(fetch_req),     32'(e.freq));
      chk("mem_req",       32'(mem_req),       32'(e.mreq));
      chk("pc_inc",        32'(pc_inc),        32'(e.pinc));
      chk("pc_load",       32'(pc_load),       32'(e.pload));
      chk("retire",        32'(retire),        32'(e.ret));
      chk("word_idx",      32'(word_idx),      32'(e.widx));
      chk("halted",        32'(halted),        32'(e.hlt));
      chk("retired_count", 32'(retired_count), 32'(e.cnt));
    end
  end

  task automatic push(input logic [5:0] st, input logic fr, input logic mr,
                      input logic pi, input logic wi);
    snap_t s;
    s.stage = st;  s.freq = fr;  s.mreq = mr;  s.pinc = pi;
    s.pload = pend_load;  s.ret = pend_ret;  s.widx = wi;
    s.hlt = exp_halt;  s.cnt = exp_cnt;
    q.push_back(s);
    pend_load = 1'b0;
    pend_ret  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset: checked immediately, released just after an edge
  task automatic do_reset(input string tag);
    reset = 1'b0;
    fetch_ready = 1'b0;  need_mem = 1'b0;  mem_ready = 1'b0;
    branch_taken = 1'b0; halt = 1'b0;      instr_words = 1'b0;
    pend_ret = 1'b0; pend_load = 1'b0; exp_cnt = '0; exp_halt = 1'b0;
    #1;
    chk({tag, "_stage"},     32'(stage),         32'h01);
    chk({tag, "_fetch_req"}, 32'(fetch_req),     32'h1);
    chk({tag, "_mem_req"},   32'(mem_req),       32'h0);
    chk({tag, "_pulses"},    32'({pc_inc, pc_load, retire}), 32'h0);
    chk({tag, "_halted"},    32'(halted),        32'h0);
    chk({tag, "_word_idx"},  32'(word_idx),      32'h0);
    chk({tag, "_count"},     32'(retired_count), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // words: 1/2; fw: IF wait cycles; mw: MEM wait cycles (-1 = no access)
  task automatic run_instr(input int words, input int fw, input int mw,
                           input logic br, input logic hlt, input logic abort);
    logic wi;
    wi = (words == 2);
    for (int w = 0; w < words; w++) begin
      for (int i = 0; i <= fw; i++) begin
        tick();
        fetch_ready = (i == fw); mem_ready = 1'b1;
        branch_taken = 1'b0; halt = 1'b0;
        push(6'h01, 1'b1, 1'b0, 1'b0, (w == 1));
      end
      tick();
      fetch_ready = 1'b1; instr_words = wi;
      push(6'h02, 1'b0, 1'b0, 1'b1, (w == 1));
    end
    tick(); push(6'h04, 1'b0, 1'b0, 1'b0, wi);
    tick(); need_mem = (mw >= 0); push(6'h08, 1'b0, 1'b0, 1'b0, wi);
    if (mw < 0) begin
      tick(); need_mem = 1'b0; mem_ready = 1'b1;
      push(6'h10, 1'b0, 1'b0, 1'b0, wi);
    end else begin
      for (int i = 0; i <= mw; i++) begin
        tick(); need_mem = 1'b1; mem_ready = (i == mw);
        push(6'h10, 1'b0, 1'b1, 1'b0, wi);
        if (abort) return;
      end
    end
    tick();
    need_mem = 1'b0; mem_ready = 1'b1; branch_taken = br; halt = hlt;
    push(6'h20, 1'b0, 1'b0, 1'b0, wi);
    pend_ret  = 1'b1;
    pend_load = br;
    exp_cnt   = exp_cnt + 1'b1;
    exp_halt  = hlt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    fetch_ready = 1'b0; instr_words = 1'b0; need_mem = 1'b0;
    mem_ready = 1'b0; branch_taken = 1'b0; halt = 1'b0;
    #2;
    do_reset("rst_init");

    // Back-to-back single-word instructions, no waits
    for (int i = 0; i < 3; i++) run_instr(1, 0, -1, 1'b0, 1'b0, 1'b0);
    // IF held 4 cycles
    run_instr(1, 4, -1, 1'b0, 1'b0, 1'b0);
    // Two-word instruction
    run_instr(2, 0, -1, 1'b0, 1'b0, 1'b0);
    // Memory access with 3 wait cycles, branch taken in WB
    run_instr(1, 0, 3, 1'b1, 1'b0, 1'b0);
    // Reset during a waiting MEM access
    run_instr(1, 0, 5, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #2;
    chk("mem_req_before_reset", 32'(mem_req), 32'h1);
    do_reset("rst_mem");

    // 17 instructions: counter wraps 15 -> 0 -> 1
    for (int i = 0; i < 17; i++)
      run_instr((i % 6 == 3) ? 2 : 1, 0, (i % 4 == 1) ? 1 : -1,
                (i % 5 == 2), 1'b0, 1'b0);

    // Halt, then 20 quiet cycles
    run_instr(1, 0, -1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      fetch_ready = 1'b1; mem_ready = 1'b1; need_mem = 1'b1; halt = 1'b0;
      push(6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    #2;
    do_reset("rst_halt");

    // Recovery after reset
    run_instr(1, 1, 0, 1'b0, 1'b0, 1'b0);
    tick(); fetch_ready = 1'b0;
    push(6'h01, 1'b1, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    @(posedge clk);
    chk("queue_drain", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_stage_controller.md
Name: cpu_stage_controller

Overview:
- Sequences the multi-cycle CPU datapath through its pipeline stages (IF, ID, OF, EX, MEM, WB) one instruction at a time.
- Drives the one-hot stage vector consumed by the datapath and exported as debug_pipeline_stage.
- Drives the PC increment/load strobes and the instruction/data memory request handshakes.
- Handles two-word instructions, memory wait states, skip-less branch loads and halt.

Parameters:
- STAGE_COUNT, 6, width of the one-hot stage vector (IF=bit0 … WB=bit5); fixed at 6, other values are illegal.
- RETIRE_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (low = reset asserted).
- stage  output  STAGE_COUNT  one-hot current stage; all-zero when halted.
- fetch_req  output  1  instruction memory request, asserted throughout IF.
- fetch_ready  input  1  instruction word valid; completes IF.
- instr_words  input  1  from decoder, valid in ID: 0 = one-word, 1 = two-word instruction.
- need_mem  input  1  from decoder, valid EX..MEM: instruction accesses data memory.
- mem_req  output  1  data memory request, asserted in MEM when need_mem=1.
- mem_ready  input  1  data access complete; completes MEM.
- branch_taken  input  1  sampled in WB: load PC instead of sequential flow.
- halt  input  1  sampled in WB: stop after this instruction.
- pc_inc  output  1  one-cycle pulse: PC += 1.
- pc_load  output  1  one-cycle pulse: PC <= branch target.
- word_idx  output  1  0 = first instruction word, 1 = second word being fetched.
- retire  output  1  one-cycle pulse when an instruction completes WB.
- retired_count  output  RETIRE_WIDTH  number of retired instructions, wraps modulo 2^RETIRE_WIDTH.
- halted  output  1  high once HALTED state entered.

Behaviour:
- States: IF, ID, OF, EX, MEM, WB, HALTED. Stage is registered; one-hot matches state; HALTED drives stage=0.
- Reset (reset low, asynchronous):
  - state=IF, stage=6'b000001, word_idx=0, retired_count=0.
  - pc_inc, pc_load, retire, mem_req and halted all 0.
  - fetch_req=1, since it is combinational from state IF.
  - Effect is immediate, mid-instruction included; no request or pulse survives reset.
- IF: fetch_req=1. Held while fetch_ready=0. When fetch_ready=1 at a rising edge: pc_inc pulses for exactly the next cycle; next state is ID.
- ID:
  - If instr_words=1 and word_idx=0: word_idx<=1, next state IF (second-word fetch).
  - Otherwise: next state OF.
  - One cycle.
- OF, EX: one cycle each; EX -> MEM.
- MEM:
  - need_mem=0: one cycle, mem_req=0, -> WB.
  - need_mem=1: mem_req=1, held until mem_ready=1; -> WB on the edge where mem_ready=1.
- WB, one cycle:
  - retire pulses next cycle; retired_count+1 (wraps); word_idx<=0.
  - branch_taken=1: pc_load pulses next cycle, never coincident with pc_inc.
  - halt=1 -> HALTED; otherwise -> IF.
- HALTED: absorbing until reset. Outputs: stage=0, halted=1, no requests, no pulses.
- Ready inputs outside their owning stage are ignored; fetch_ready and mem_ready never advance any other stage.
- Single-word, no-wait-state instruction latency: 6 cycles IF..WB. Two-word instruction: 8 cycles.
- pc_inc and pc_load are mutually exclusive in every cycle. At most one retire per instruction.

Decomposition:
- Shared defines header (defines.vh) holds:
  - STAGE_COUNT;
  - stage bit indices STAGE_IF..STAGE_WB;
  - state encodings;
  - RETIRE_WIDTH.
- These keep the datapath, debug port and this block consistent.
- One natural sub-module: retire_counter, a wrapping enable counter with async active-low reset. Everything else is a single FSM.

Test Plan:
- Reset, then fetch_ready=mem_ready=1 continuously, one-word instructions, need_mem=0 -> stage cycles 1,2,4,8,16,32; pc_inc once per 6 cycles; retired_count=3 after 18 cycles.
- fetch_ready held low 4 cycles in IF -> stage stays 6'b000001 for 5 cycles, fetch_req high throughout, single pc_inc after acceptance.
- instr_words=1 -> IF,ID,IF(word_idx=1),ID,OF,EX,MEM,WB: 8 cycles, two pc_inc pulses, one retire.
- need_mem=1, mem_ready low 3 cycles -> MEM lasts 4 cycles, mem_req high exactly those 4 cycles; branch_taken=1 in WB -> pc_load pulse, no pc_inc that cycle.
- halt=1 in WB -> stage=0, halted=1, no requests for 20 cycles; reset low mid-HALTED -> IF, retired_count=0.
- RETIRE_WIDTH=4, 17 instructions -> retired_count wraps 15->0->1; assert reset low during MEM with mem_req=1 -> mem_req drops asynchronously.
